regfile_wb_queue: RTL and testbench

Write-back queue that sits between the pipeline's write-back stage and the 32x32 register file, acting as the write-side initiator for the register file's write port (WE/Rw/busW).

- Buffers up to DEPTH register writes and drains them into the register file at one write per cycle.
- Gives a debug/loader write port priority over queued writes.
- Forwards pending queued data onto the read buses so readers never see stale values.

---
 rtl/rf_wb_pkg.sv | 13 +
 rtl/rf_wb_fifo.sv | 73 +++++++
 rtl/regfile_wb_queue.sv | 98 +++++++++
 tb/tb_regfile_wb_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared defaults and types for the register-file write-back queue.
package rf_wb_pkg;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned REG_ZERO  = 0;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Write-back FIFO storage: pointers, occupancy and per-entry visibility for forwarding.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic [AW-1:0]             i_push_addr,
    input  logic [DW-1:0]             i_push_data,
    input  logic                      i_pop,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [PW:0]               o_count,
    output logic [AW-1:0]             o_head_addr,
    output logic [DW-1:0]             o_head_data,
    output logic [PW-1:0]             o_wr_ptr,
    output logic [DEPTH-1:0]          o_valid,
    output logic [DEPTH-1:0][AW-1:0]  o_addr,
    output logic [DEPTH-1:0][DW-1:0]  o_data
);
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW:0]              r_count;
    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // push and pop never share an index: that would need empty+pop or full+push
            if (i_push) begin
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_full      = (r_count == (PW+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_wr_ptr    = r_wr_ptr;
    assign o_valid     = r_valid;
    assign o_addr      = r_addr;
    assign o_data      = r_data;
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port, with debug-write priority
// and forwarding of pending queued data onto both read buses.
module regfile_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           in_addr,
    input  logic [DW-1:0]           in_data,
    input  logic                    dbg_we,
    input  logic [AW-1:0]           dbg_addr,
    input  logic [DW-1:0]           dbg_data,
    output logic                    WE,
    output logic [AW-1:0]           Rw,
    output logic [DW-1:0]           busW,
    input  logic [AW-1:0]           Ra,
    input  logic [AW-1:0]           Rb,
    input  logic [DW-1:0]           rf_busA,
    input  logic [DW-1:0]           rf_busB,
    output logic [DW-1:0]           busA,
    output logic [DW-1:0]           busB,
    output logic [$clog2(DEPTH):0]  pend_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [AW-1:0]            w_head_addr;
    logic [DW-1:0]            w_head_data;
    logic [PW-1:0]            w_wr_ptr;
    logic [DEPTH-1:0]         w_valid;
    logic [DEPTH-1:0][AW-1:0] w_addr;
    logic [DEPTH-1:0][DW-1:0] w_data;
    logic [PW-1:0]            w_idx;

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready && (in_addr != AW'(REG_ZERO));
    assign w_pop    = !dbg_we && !w_empty;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_push      (w_push),
        .i_push_addr (in_addr),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (pend_cnt),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_wr_ptr    (w_wr_ptr),
        .o_valid     (w_valid),
        .o_addr      (w_addr),
        .o_data      (w_data)
    );

    always_comb begin
        WE   = 1'b0;
        Rw   = '0;
        busW = '0;
        if (dbg_we) begin
            WE   = 1'b1;
            Rw   = dbg_addr;
            busW = dbg_data;
        end else if (!w_empty) begin
            WE   = 1'b1;
            Rw   = w_head_addr;
            busW = w_head_data;
        end
    end

    // Walk oldest slot (wr_ptr) to newest (wr_ptr-1); later matches override, so newest wins.
    always_comb begin
        busA  = rf_busA;
        busB  = rf_busB;
        w_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = w_wr_ptr - PW'(DEPTH - k);
            if (w_valid[w_idx] && (Ra != AW'(REG_ZERO)) && (w_addr[w_idx] == Ra))
                busA = w_data[w_idx];
            if (w_valid[w_idx] && (Rb != AW'(REG_ZERO)) && (w_addr[w_idx] == Rb))
                busB = w_data[w_idx];
        end
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a queue-level reference model and a register-file model.
module tb_regfile_wb_queue;
    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data = '0;
    logic        WE;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [4:0]  Ra = '0;
    logic [4:0]  Rb = '0;
    logic [31:0] rf_busA;
    logic [31:0] rf_busB;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [2:0]  pend_cnt;

    logic [31:0] rf [32];
    logic [36:0] mq [$];
    int total = 0;
    int bad   = 0;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .WE(WE), .Rw(Rw), .busW(busW),
        .Ra(Ra), .Rb(Rb), .rf_busA(rf_busA), .rf_busB(rf_busB),
        .busA(busA), .busB(busB), .pend_cnt(pend_cnt)
    );

    always #5 CLK = ~CLK;

    assign rf_busA = rf[Ra];
    assign rf_busB = rf[Rb];

    function automatic logic [31:0] init_val(int i);
        return (i == 0) ? 32'h0 : 32'hC000_0000 + 32'(i);
    endfunction

    // Register file: captures on the falling edge; register 0 is hardwired to zero.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = init_val(i);
        forever begin
            @(negedge CLK);
            if (WE && Rw != 5'd0) rf[Rw] = busW;
        end
    end

    // Reference model: list of pending writes, oldest first.
    initial begin
        forever begin
            bit do_pop, do_push;
            @(posedge CLK or posedge RST);
            if (RST) begin
                mq.delete();
            end else begin
                do_pop  = !dbg_we && (mq.size() > 0);
                do_push = in_valid && (mq.size() < DEPTH) && (in_addr != 5'd0);
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back({in_addr, in_data});
            end
        end
    end

    function automatic logic [31:0] fwd(logic [4:0] ra, logic [31:0] raw);
        logic [36:0] e;
        fwd = raw;
        if (ra != 5'd0)
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e[36:32] == ra) fwd = e[31:0];
            end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [36:0] h;
        forever begin
            @(negedge CLK);
            #1;
            h = (mq.size() > 0) ? mq[0] : 37'h0;
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("m_pend_cnt", 32'(pend_cnt), 32'(mq.size()));
            chk("m_WE", 32'(WE), 32'(dbg_we || mq.size() > 0));
            chk("m_Rw", 32'(Rw), dbg_we ? 32'(dbg_addr) : 32'(h[36:32]));
            chk("m_busW", busW, dbg_we ? dbg_data : h[31:0]);
            chk("m_busA", busA, fwd(Ra, rf[Ra]));
            chk("m_busB", busB, fwd(Rb, rf[Rb]));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) step();
        RST = 1'b0;
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(WE), 32'd0);

        // single push drains next cycle
        in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hA5A5A5A5;
        step();
        chk("t1_pend1", 32'(pend_cnt), 32'd1);
        chk("t1_we", 32'(WE), 32'd1);
        chk("t1_rw", 32'(Rw), 32'd5);
        chk("t1_busw", busW, 32'hA5A5A5A5);
        in_valid = 1'b0;
        step();
        chk("t1_pend0", 32'(pend_cnt), 32'd0);
        chk("t1_rf5", rf[5], 32'hA5A5A5A5);

        // debug priority stalls draining and fills the queue
        dbg_we = 1'b1; dbg_addr = 5'd3; dbg_data = 32'h33;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_addr  = (c < 4) ? 5'(c + 1) : 5'd5;
            in_data  = 32'h100 + 32'(in_addr);
            step();
        end
        chk("t2_pend4", 32'(pend_cnt), 32'd4);
        chk("t2_notready", 32'(in_ready), 32'd0);
        chk("t2_dbg_rw", 32'(Rw), 32'd3);
        dbg_we = 1'b0;
        #1;
        chk("t2_rw1", 32'(Rw), 32'd1);
        step();
        chk("t2_rw2", 32'(Rw), 32'd2);
        chk("t2_ready", 32'(in_ready), 32'd1);
        step();
        chk("t2_rw3", 32'(Rw), 32'd3);
        chk("t2_pend3", 32'(pend_cnt), 32'd3);
        in_valid = 1'b0;
        step();
        chk("t2_rw4", 32'(Rw), 32'd4);
        step();
        chk("t2_rw5", 32'(Rw), 32'd5);
        step();
        chk("t2_idle_we", 32'(WE), 32'd0);
        chk("t2_rf3", rf[3], 32'h103);
        chk("t2_rf5", rf[5], 32'h105);

        // forwarding of newest match
        dbg_we = 1'b1; dbg_addr = 5'd31; dbg_data = 32'hDB;
        Ra = 5'd7; Rb = 5'd8;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
        step();
        chk("t3_fwd11", busA, 32'h11);
        in_data = 32'h22;
        step();
        chk("t3_fwd22", busA, 32'h22);
        chk("t3_busb_raw", busB, 32'hC0000008);
        chk("t3_pend2", 32'(pend_cnt), 32'd2);
        in_valid = 1'b0; dbg_we = 1'b0;
        step();
        chk("t3_fwd22_b", busA, 32'h22);
        chk("t3_pend1", 32'(pend_cnt), 32'd1);
        step();
        chk("t3_pend0", 32'(pend_cnt), 32'd0);
        chk("t3_rf7", busA, 32'h22);

        // writes to register 0 are accepted and dropped
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
        step();
        chk("t4_pend", 32'(pend_cnt), 32'd0);
        chk("t4_we", 32'(WE), 32'd0);
        chk("t4_ready", 32'(in_ready), 32'd1);

        // continuous streaming wraps the pointers
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 32'h200 + 32'(i);
            step();
            chk("t5_pend", 32'(pend_cnt), 32'd1);
            chk("t5_ready", 32'(in_ready), 32'd1);
            chk("t5_rw", 32'(Rw), 32'(10 + i));
        end
        in_valid = 1'b0;
        step();
        chk("t5_pend0", 32'(pend_cnt), 32'd0);
        for (int i = 0; i < 10; i++) chk("t5_rf", rf[10 + i], 32'h200 + 32'(i));

        // asynchronous reset mid-cycle discards pending writes
        dbg_we = 1'b1; dbg_addr = 5'd31;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 5'(20 + i); in_data = 32'h300 + 32'(i);
            step();
        end
        chk("t6_pend3", 32'(pend_cnt), 32'd3);
        in_valid = 1'b0; dbg_we = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("t6_rst_pend", 32'(pend_cnt), 32'd0);
        chk("t6_rst_we", 32'(WE), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        step();
        RST = 1'b0;
        step();
        step();
        chk("t6_pend_after", 32'(pend_cnt), 32'd0);
        for (int i = 0; i < 3; i++) chk("t6_rf_untouched", rf[20 + i], init_val(20 + i));

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
